dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-requester controller for the single-port 64-word data memory: port 0 = CPU load/store, port 1 = debug/DMA loader.
//  Arbitrates, sequences each access as IDLE->ISSUE->RESP, drives memory address/data/read/write, returns read data with valid/ready.
//  Sits between the pipeline MEM stage (plus loader) and the data memory, which writes on CLK falling edge and reads combinationally.
// PARAMETERS
//  DEPTH       64  words implemented in memory; address >= DEPTH is an error
//  DATA_WIDTH  32  data width
//  ADDR_WIDTH  32  request/memory address width
// PORTS
//  CLK            in   1   clock, all state on rising edge
//  reset          in   1   synchronous, active-high reset
//  pN_req_valid   in   1   (N=0,1) request present
//  pN_req_ready   out  1   request accepted this cycle (combinational)
//  pN_req_addr    in   32  word address
//  pN_req_wdata   in   32  write data
//  pN_req_we      in   1   1=write, 0=read
//  pN_rsp_valid   out  1   response valid
//  pN_rsp_ready   in   1   requester takes response
//  pN_rsp_rdata   out  32  read data (0 for writes/errors)
//  pN_rsp_err     out  1   address out of range
//  mem_address    out  32  to memory address
//  mem_writeData  out  32  to memory writeData
//  mem_memWrite   out  1   to memory memWrite
//  mem_memRead    out  1   to memory memRead
//  mem_readData   in   32  from memory readData
//  busy           out  1   state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer favours port 0, all outputs and captured regs 0.
//  IDLE: grant one valid requester; pN_req_ready=1 only for grantee, only in IDLE; latch addr/wdata/we/port; ->ISSUE.
//  Arbitration: round-robin; both valid -> grant port != last grantee; single valid -> grant it. Pointer updates on grant.
//  ISSUE (1 cycle): registered mem_* outputs hold latched address/data; mem_memWrite=we, mem_memRead=!we.
//   Write commits at this cycle's falling edge. On the rising edge ending ISSUE, capture mem_readData (read) or 0 (write); ->RESP.
//  RESP: pN_rsp_valid=1 for grantee; rdata/err stable; mem_memRead/mem_memWrite=0; mem_address holds.
//   When rsp_ready=1 -> IDLE next cycle. No new grant in the same cycle as the response handshake.
//  Latency: accept at cycle t, rsp_valid at t+2; minimum 3 cycles per transaction.
//  Out of range (addr >= DEPTH): ISSUE still spent, mem_memRead/mem_memWrite stay 0, rsp_err=1, rdata=0, memory untouched.
//  Requests held while not ready must stay stable; non-granted port waits, is not dropped.
//  Reset mid-operation: pending response discarded, -> IDLE; a write whose ISSUE falling edge already passed stays committed.
//  Only one port's rsp_valid is high at any time; never two outstanding transactions.
// CONFIGURATION
//  DMEM_ARB_FIXED_PRIO_EN defined: fixed priority, port 0 always wins when both valid; rr pointer removed.
//  Not defined: round-robin as above (default build).
// TESTING
//  1 Reset then p0 write addr 5 data 0xDEADBEEF -> memWrite=1 one cycle, p0_rsp_valid at t+2, err=0, rdata=0.
//  2 p0 read addr 5 -> memRead=1 in ISSUE, p0_rsp_rdata=0xDEADBEEF at t+2.
//  3 p0 and p1 both valid continuously (reads addr 1/2) -> grants alternate 0,1,0,1; with DMEM_ARB_FIXED_PRIO_EN all go to p0.
//  4 p1 read addr 64 -> memRead/memWrite stay 0, p1_rsp_err=1, rdata=0; addr 63 -> err=0.
//  5 p0 read with rsp_ready=0 for 4 cycles -> rsp_valid/rdata held, p1 not granted, busy=1; ready=1 -> IDLE next cycle.
//  6 reset during RESP of p0 write addr 7 0x1234 -> outputs 0, IDLE; subsequent read addr 7 returns 0x1234.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port controller sequencing IDLE->ISSUE->RESP accesses to a single-port data memory.
// Optional macro DMEM_ARB_FIXED_PRIO_EN: fixed priority (port 0 wins); otherwise round-robin.
module dmem_arbiter #(
    parameter int DEPTH      = 64,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  reset,

    input  logic                  p0_req_valid,
    output logic                  p0_req_ready,
    input  logic [ADDR_WIDTH-1:0] p0_req_addr,
    input  logic [DATA_WIDTH-1:0] p0_req_wdata,
    input  logic                  p0_req_we,
    output logic                  p0_rsp_valid,
    input  logic                  p0_rsp_ready,
    output logic [DATA_WIDTH-1:0] p0_rsp_rdata,
    output logic                  p0_rsp_err,

    input  logic                  p1_req_valid,
    output logic                  p1_req_ready,
    input  logic [ADDR_WIDTH-1:0] p1_req_addr,
    input  logic [DATA_WIDTH-1:0] p1_req_wdata,
    input  logic                  p1_req_we,
    output logic                  p1_rsp_valid,
    input  logic                  p1_rsp_ready,
    output logic [DATA_WIDTH-1:0] p1_rsp_rdata,
    output logic                  p1_rsp_err,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writeData,
    output logic                  mem_memWrite,
    output logic                  mem_memRead,
    input  logic [DATA_WIDTH-1:0] mem_readData,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  nextState_s;

    logic                    grantValid_s;
    logic                    grantPort_s;
    logic [ADDR_WIDTH-1:0]   selAddr_s;
    logic [DATA_WIDTH-1:0]   selWdata_s;
    logic                    selWe_s;
    logic                    selInRange_s;
    logic                    rspReady_s;
    logic [DATA_WIDTH-1:0]   rdataCapture_s;

    logic                    port_r;
    logic                    we_r;
    logic                    err_r;

    function automatic logic addrInRange(input logic [ADDR_WIDTH-1:0] addr);
        return (addr < ADDR_WIDTH'(DEPTH));
    endfunction

`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic                    lastGrant_r;

    // Round-robin pointer: remembers the most recent grantee; reset value makes port 0 win first.
    always_ff @(posedge CLK) begin
        if (reset) begin
            lastGrant_r <= 1'b1;
        end else if (grantValid_s) begin
            lastGrant_r <= grantPort_s;
        end else begin
            lastGrant_r <= lastGrant_r;
        end
    end
`endif

    // Arbitration: a grant can only be issued while idle.
    always_comb begin
        grantValid_s = 1'b0;
        grantPort_s  = 1'b0;
        if (state_r == IDLE) begin
            if (p0_req_valid && p1_req_valid) begin
                grantValid_s = 1'b1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
                grantPort_s  = 1'b0;
`else
                grantPort_s  = ~lastGrant_r;
`endif
            end else if (p0_req_valid) begin
                grantValid_s = 1'b1;
                grantPort_s  = 1'b0;
            end else if (p1_req_valid) begin
                grantValid_s = 1'b1;
                grantPort_s  = 1'b1;
            end else begin
                grantValid_s = 1'b0;
                grantPort_s  = 1'b0;
            end
        end else begin
            grantValid_s = 1'b0;
            grantPort_s  = 1'b0;
        end
    end

    // Request mux for the grantee plus response-side helpers.
    always_comb begin
        selAddr_s      = p0_req_addr;
        selWdata_s     = p0_req_wdata;
        selWe_s        = p0_req_we;
        if (grantPort_s) begin
            selAddr_s  = p1_req_addr;
            selWdata_s = p1_req_wdata;
            selWe_s    = p1_req_we;
        end else begin
            selAddr_s  = p0_req_addr;
            selWdata_s = p0_req_wdata;
            selWe_s    = p0_req_we;
        end
        selInRange_s   = addrInRange(selAddr_s);
        rspReady_s     = port_r ? p1_rsp_ready : p0_rsp_ready;
        if (we_r || err_r) begin
            rdataCapture_s = {DATA_WIDTH{1'b0}};
        end else begin
            rdataCapture_s = mem_readData;
        end
    end

    assign p0_req_ready = grantValid_s && !grantPort_s;
    assign p1_req_ready = grantValid_s && grantPort_s;

    // Next-state logic for the access sequencer.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (grantValid_s) begin
                    nextState_s = ISSUE;
                end else begin
                    nextState_s = IDLE;
                end
            end
            ISSUE: begin
                nextState_s = RESP;
            end
            RESP: begin
                if (rspReady_s) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s = RESP;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State register, captured request and all registered outputs.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_r       <= IDLE;
            busy          <= 1'b0;
            port_r        <= 1'b0;
            we_r          <= 1'b0;
            err_r         <= 1'b0;
            mem_address   <= {ADDR_WIDTH{1'b0}};
            mem_writeData <= {DATA_WIDTH{1'b0}};
            mem_memWrite  <= 1'b0;
            mem_memRead   <= 1'b0;
            p0_rsp_valid  <= 1'b0;
            p0_rsp_rdata  <= {DATA_WIDTH{1'b0}};
            p0_rsp_err    <= 1'b0;
            p1_rsp_valid  <= 1'b0;
            p1_rsp_rdata  <= {DATA_WIDTH{1'b0}};
            p1_rsp_err    <= 1'b0;
        end else begin
            state_r <= nextState_s;
            busy    <= (nextState_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (grantValid_s) begin
                        port_r        <= grantPort_s;
                        we_r          <= selWe_s;
                        err_r         <= !selInRange_s;
                        mem_address   <= selAddr_s;
                        mem_writeData <= selWdata_s;
                        // Out-of-range accesses never strobe the memory.
                        mem_memWrite  <= selWe_s && selInRange_s;
                        mem_memRead   <= !selWe_s && selInRange_s;
                    end
                end
                ISSUE: begin
                    mem_memWrite <= 1'b0;
                    mem_memRead  <= 1'b0;
                    if (port_r) begin
                        p1_rsp_valid <= 1'b1;
                        p1_rsp_rdata <= rdataCapture_s;
                        p1_rsp_err   <= err_r;
                    end else begin
                        p0_rsp_valid <= 1'b1;
                        p0_rsp_rdata <= rdataCapture_s;
                        p0_rsp_err   <= err_r;
                    end
                end
                RESP: begin
                    if (rspReady_s) begin
                        p0_rsp_valid <= 1'b0;
                        p0_rsp_rdata <= {DATA_WIDTH{1'b0}};
                        p0_rsp_err   <= 1'b0;
                        p1_rsp_valid <= 1'b0;
                        p1_rsp_rdata <= {DATA_WIDTH{1'b0}};
                        p1_rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    mem_memWrite <= 1'b0;
                    mem_memRead  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a response/memory-strobe scoreboard checked by a negedge monitor.
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        reset;
    logic        p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_ready, p0_rsp_err;
    logic [31:0] p0_req_addr, p0_req_wdata, p0_rsp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid, p1_rsp_ready, p1_rsp_err;
    logic [31:0] p1_req_addr, p1_req_wdata, p1_rsp_rdata;
    logic [31:0] mem_address, mem_writeData, mem_readData;
    logic        mem_memWrite, mem_memRead, busy;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } rspExp_t;

    typedef struct {
        int          cyc;
        logic        wr;
        logic        rd;
        logic [31:0] addr;
    } memExp_t;

    rspExp_t     expQ[$];
    memExp_t     memQ[$];
    int          grantLog[$];
    int          passCnt = 0;
    int          totalCnt = 0;
    int          cyc = 0;
    int          activeDrivers = 0;
    bit          monEn = 1'b0;
    logic        prevValid = 1'b0;
    logic [31:0] memArr [0:63];

    dmem_arbiter dut (
        .CLK(CLK), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_addr(p0_req_addr),
        .p0_req_wdata(p0_req_wdata), .p0_req_we(p0_req_we), .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_addr(p1_req_addr),
        .p1_req_wdata(p1_req_wdata), .p1_req_we(p1_req_we), .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
        .mem_address(mem_address), .mem_writeData(mem_writeData), .mem_memWrite(mem_memWrite),
        .mem_memRead(mem_memRead), .mem_readData(mem_readData), .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Data memory: combinational read, write on falling edge.
    assign mem_readData = memArr[mem_address[5:0]];
    always @(negedge CLK) begin
        if (mem_memWrite) memArr[mem_address[5:0]] <= mem_writeData;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor: memory strobes each cycle, responses on their first valid cycle.
    always @(negedge CLK) begin
        if (monEn) begin
            chk("one_rsp_valid", 32'(p0_rsp_valid && p1_rsp_valid), 32'd0);
            if (memQ.size() > 0 && memQ[0].cyc == cyc) begin
                chk("mem_memWrite", 32'(mem_memWrite), 32'(memQ[0].wr));
                chk("mem_memRead", 32'(mem_memRead), 32'(memQ[0].rd));
                chk("mem_address", mem_address, memQ[0].addr);
                memQ.delete(0);
            end else begin
                chk("mem_strobes_idle", {30'd0, mem_memWrite, mem_memRead}, 32'd0);
            end
            if ((p0_rsp_valid || p1_rsp_valid) && !prevValid) begin
                if (expQ.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("rsp_port", p1_rsp_valid ? 32'd1 : 32'd0, 32'(expQ[0].port));
                    chk("rsp_rdata", p1_rsp_valid ? p1_rsp_rdata : p0_rsp_rdata, expQ[0].rdata);
                    chk("rsp_err", 32'(p1_rsp_valid ? p1_rsp_err : p0_rsp_err), 32'(expQ[0].err));
                    chk("rsp_latency", 32'(cyc), 32'(expQ[0].acc + 2));
                    expQ.delete(0);
                end
            end
            prevValid <= p0_rsp_valid || p1_rsp_valid;
        end
    end

    task automatic doReq(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic we, input logic [31:0] expRdata, input logic expErr);
        bit   accepted;
        logic inR;
        accepted = 1'b0;
        inR = (addr < 32'd64);
        activeDrivers++;
        if (port == 0) begin
            p0_req_valid = 1'b1; p0_req_addr = addr; p0_req_wdata = wdata; p0_req_we = we;
        end else begin
            p1_req_valid = 1'b1; p1_req_addr = addr; p1_req_wdata = wdata; p1_req_we = we;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if ((port == 0) ? p0_req_ready : p1_req_ready) begin
                expQ.push_back('{port, expRdata, expErr, cyc});
                memQ.push_back('{cyc + 1, we && inR, !we && inR, addr});
                grantLog.push_back(port);
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) chk("accept_timeout", 32'd1, 32'd0);
        @(posedge CLK);
        #1;
        if (port == 0) p0_req_valid = 1'b0;
        else p1_req_valid = 1'b0;
        activeDrivers--;
    endtask

    task automatic waitDone();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (activeDrivers == 0 && expQ.size() == 0 && memQ.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("wait_done_timeout", 32'd1, 32'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int expOrder[4];
        int startIdx;
        reset = 1'b1;
        p0_req_valid = 1'b0; p0_req_addr = 32'd0; p0_req_wdata = 32'd0; p0_req_we = 1'b0;
        p1_req_valid = 1'b0; p1_req_addr = 32'd0; p1_req_wdata = 32'd0; p1_req_we = 1'b0;
        p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1 reset = 1'b0;
        @(negedge CLK);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", {30'd0, p0_rsp_valid, p1_rsp_valid}, 32'd0);
        chk("reset_strobes", {30'd0, mem_memWrite, mem_memRead}, 32'd0);
        chk("reset_mem_address", mem_address, 32'd0);
        chk("reset_rdata", p0_rsp_rdata | p1_rsp_rdata, 32'd0);
        chk("reset_req_ready", {30'd0, p0_req_ready, p1_req_ready}, 32'd0);
        monEn = 1'b1;
        @(posedge CLK);
        #1;

        // write then read back through port 0
        doReq(0, 32'd5, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0);
        waitDone();
        doReq(0, 32'd5, 32'd0, 1'b0, 32'hDEADBEEF, 1'b0);
        waitDone();

        // preload via port 1
        doReq(1, 32'd1, 32'h11111111, 1'b1, 32'd0, 1'b0);
        doReq(1, 32'd2, 32'h22222222, 1'b1, 32'd0, 1'b0);
        doReq(1, 32'd63, 32'h63636363, 1'b1, 32'd0, 1'b0);
        waitDone();

        // both ports contend continuously
        startIdx = grantLog.size();
        fork
            begin
                doReq(0, 32'd1, 32'd0, 1'b0, 32'h11111111, 1'b0);
                doReq(0, 32'd1, 32'd0, 1'b0, 32'h11111111, 1'b0);
            end
            begin
                doReq(1, 32'd2, 32'd0, 1'b0, 32'h22222222, 1'b0);
                doReq(1, 32'd2, 32'd0, 1'b0, 32'h22222222, 1'b0);
            end
        join
        waitDone();
`ifdef DMEM_ARB_FIXED_PRIO_EN
        expOrder = '{0, 0, 1, 1};
`else
        expOrder = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            if (startIdx + i < grantLog.size()) chk("grant_order", 32'(grantLog[startIdx + i]), 32'(expOrder[i]));
            else chk("grant_order_missing", 32'd1, 32'd0);
        end

        // out-of-range and last valid address
        doReq(1, 32'd64, 32'd0, 1'b0, 32'd0, 1'b1);
        waitDone();
        doReq(1, 32'd63, 32'd0, 1'b0, 32'h63636363, 1'b0);
        waitDone();
        doReq(1, 32'd100, 32'hBAD0BAD0, 1'b1, 32'd0, 1'b1);
        waitDone();

        // response back-pressure blocks the other port
        p0_rsp_ready = 1'b0;
        doReq(0, 32'd5, 32'd0, 1'b0, 32'hDEADBEEF, 1'b0);
        fork
            doReq(1, 32'd63, 32'd0, 1'b0, 32'h63636363, 1'b0);
        join_none
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("hold_rsp_valid", 32'(p0_rsp_valid), 32'd1);
            chk("hold_rdata", p0_rsp_rdata, 32'hDEADBEEF);
            chk("hold_busy", 32'(busy), 32'd1);
            chk("hold_p1_not_granted", 32'(p1_req_ready), 32'd0);
        end
        @(posedge CLK);
        #1 p0_rsp_ready = 1'b1;
        @(negedge CLK);
        chk("handshake_rsp_valid", 32'(p0_rsp_valid), 32'd1);
        @(negedge CLK);
        chk("after_handshake_busy", 32'(busy), 32'd0);
        chk("after_handshake_rsp_valid", 32'(p0_rsp_valid), 32'd0);
        chk("after_handshake_p1_granted", 32'(p1_req_ready), 32'd1);
        waitDone();

        // reset while a write response is pending
        p0_rsp_ready = 1'b0;
        doReq(0, 32'd7, 32'h00001234, 1'b1, 32'd0, 1'b0);
        @(negedge CLK);
        @(negedge CLK);
        chk("pre_reset_rsp_valid", 32'(p0_rsp_valid), 32'd1);
        @(posedge CLK);
        #1 reset = 1'b1;
        @(posedge CLK);
        #1 reset = 1'b0;
        p0_rsp_ready = 1'b1;
        @(negedge CLK);
        chk("mid_reset_rsp_valid", 32'(p0_rsp_valid), 32'd0);
        chk("mid_reset_busy", 32'(busy), 32'd0);
        chk("mid_reset_mem_address", mem_address, 32'd0);
        chk("mid_reset_err", 32'(p0_rsp_err), 32'd0);
        @(posedge CLK);
        #1;
        doReq(0, 32'd7, 32'd0, 1'b0, 32'h00001234, 1'b0);
        waitDone();

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
